// File: rtl/p_det_scheduler_pkg.sv
// Shared types for the parameter-set scheduler:
// the selector type, the default set count and the FSM states.
package p_det_scheduler_pkg;

    localparam int P_DET_W      = 5;
    localparam int NUM_SETS_DEF = 30;

    typedef logic [P_DET_W-1:0] p_det_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SETTLE,
        HOLD
    } state_t;

    localparam p_det_t P_DET_RST = 5'd1;

endpackage

// File: rtl/p_det_scheduler_if.sv
// Scheduler bundle: datapath request/release handshake,
// random-word stream and the registered selector outputs.
interface p_det_scheduler_if;
    import p_det_scheduler_pkg::*;

    logic   req;
    logic   done;
    logic   rnd_valid;
    p_det_t rnd_data;
    logic   rnd_ready;
    p_det_t p_det;
    logic   ack;
    logic   fallback;

    modport master (
        output req,
        output done,
        output rnd_valid,
        output rnd_data,
        input  rnd_ready,
        input  p_det,
        input  ack,
        input  fallback
    );

    modport slave (
        input  req,
        input  done,
        input  rnd_valid,
        input  rnd_data,
        output rnd_ready,
        output p_det,
        output ack,
        output fallback
    );

endinterface

// File: rtl/p_det_sampler.sv
// Judges a random word against the legal range and the current
// selector, and supplies the round-robin fallback selector.
module p_det_sampler
    import p_det_scheduler_pkg::*;
#(
    parameter int NUM_SETS     = NUM_SETS_DEF,
    parameter int AVOID_REPEAT = 1
) (
    input  p_det_t rnd_data,
    input  p_det_t p_det,
    output logic   accept,
    output p_det_t fb_val
);
    localparam p_det_t LAST = p_det_t'(NUM_SETS);

    logic in_range;
    logic repeat_hit;

    assign in_range   = (rnd_data != '0) && (rnd_data <= LAST);
    assign repeat_hit = (AVOID_REPEAT != 0) && (rnd_data == p_det);
    assign accept     = in_range && !repeat_hit;

    // p_det is always in 1..NUM_SETS, so this is (p_det mod N) + 1
    assign fb_val = (p_det >= LAST) ? P_DET_RST : p_det + 5'd1;

endmodule

// File: rtl/p_det_scheduler.sv
// Picks a random parameter set on request, lets the extractor
// settle, then holds it with ack until the datapath releases it.
module p_det_scheduler
    import p_det_scheduler_pkg::*;
#(
    parameter int NUM_SETS      = NUM_SETS_DEF,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_REJECT    = 8,
    parameter int AVOID_REPEAT  = 1
) (
    input logic              clk,
    input logic              rst_n,
    p_det_scheduler_if.slave bus
);
    localparam logic [7:0] REJ_LAST = 8'(MAX_REJECT - 1);
    localparam logic [3:0] SET_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    p_det_t     p_det_q;
    logic       ack_q;
    logic       fb_q;
    logic [7:0] rej_cnt;
    logic [3:0] set_cnt;
    logic       accept;
    p_det_t     fb_val;

    p_det_sampler #(
        .NUM_SETS     (NUM_SETS),
        .AVOID_REPEAT (AVOID_REPEAT)
    ) u_sampler (
        .rnd_data (bus.rnd_data),
        .p_det    (p_det_q),
        .accept   (accept),
        .fb_val   (fb_val)
    );

    assign bus.rnd_ready = (state == DRAW);
    assign bus.p_det     = p_det_q;
    assign bus.ack       = ack_q;
    assign bus.fallback  = fb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            p_det_q <= P_DET_RST;
            ack_q   <= 1'b0;
            fb_q    <= 1'b0;
            rej_cnt <= '0;
            set_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req) state <= DRAW;
                end
                DRAW: begin
                    // a dropped request wins over a same-cycle draw
                    if (!bus.req) begin
                        state   <= IDLE;
                        rej_cnt <= '0;
                    end else if (bus.rnd_valid) begin
                        if (accept) begin
                            p_det_q <= bus.rnd_data;
                            fb_q    <= 1'b0;
                            rej_cnt <= '0;
                            set_cnt <= '0;
                            state   <= SETTLE;
                        end else if (rej_cnt == REJ_LAST) begin
                            p_det_q <= fb_val;
                            fb_q    <= 1'b1;
                            rej_cnt <= '0;
                            set_cnt <= '0;
                            state   <= SETTLE;
                        end else begin
                            rej_cnt <= rej_cnt + 8'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (!bus.req) begin
                        state   <= IDLE;
                        set_cnt <= '0;
                    end else if (set_cnt == SET_LAST) begin
                        state   <= HOLD;
                        ack_q   <= 1'b1;
                        set_cnt <= '0;
                    end else begin
                        set_cnt <= set_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.done) begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
